// File: rtl/flash_seq_pkg.sv
// -----------------------------------------------------------------------------
// flash_seq_pkg
// Shared definitions for the SPI NOR flash operation sequencer:
//   - SPI flash opcodes (write enable, chip/sector erase, page program,
//     read, read status register)
//   - op_code encodings presented on the sequencer request port
//   - sequencer and handshake state encodings
//   - transfer descriptor (length in bits + right-justified transmit data)
//     and the helper that builds the command transfer for an operation
//   - saturating 16-bit increment used by the poll counter
// -----------------------------------------------------------------------------
package flash_seq_pkg;

    localparam logic [7:0] OPC_WREN = 8'h06;
    localparam logic [7:0] OPC_CE   = 8'hC7;
    localparam logic [7:0] OPC_SE   = 8'h20;
    localparam logic [7:0] OPC_PP   = 8'h02;
    localparam logic [7:0] OPC_READ = 8'h03;
    localparam logic [7:0] OPC_RDSR = 8'h05;

    localparam logic [1:0] OP_CHIP_ERASE = 2'd0;
    localparam logic [1:0] OP_SECT_ERASE = 2'd1;
    localparam logic [1:0] OP_PROGRAM    = 2'd2;
    localparam logic [1:0] OP_READ       = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREN,
        ST_CMD,
        ST_POLL,
        ST_XWAIT,
        ST_GAP,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_RISE,
        HS_FALL,
        HS_GAP
    } hs_phase_e;

    typedef struct packed {
        logic [7:0]   len;
        logic [127:0] tx;
    } xfer_t;

    localparam xfer_t XFER_WREN = '{len: 8'd8,  tx: 128'(OPC_WREN)};
    localparam xfer_t XFER_RDSR = '{len: 8'd16, tx: 128'({OPC_RDSR, 8'h00})};

    // Command transfer for an operation; the read carries one dummy byte
    // slot whose receive byte lands in spi_rx[7:0].
    function automatic xfer_t cmd_xfer(input logic [1:0]  code,
                                       input logic [23:0] addr,
                                       input logic [7:0]  wdata);
        xfer_t x;
        x.len = 8'd8;
        x.tx  = 128'(OPC_CE);
        case (code)
            OP_SECT_ERASE: begin
                x.len = 8'd32;
                x.tx  = 128'({OPC_SE, addr});
            end
            OP_PROGRAM: begin
                x.len = 8'd40;
                x.tx  = 128'({OPC_PP, addr, wdata});
            end
            OP_READ: begin
                x.len = 8'd40;
                x.tx  = 128'({OPC_READ, addr, 8'h00});
            end
            default: ;
        endcase
        return x;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/flash_xfer_hs.sv
// -----------------------------------------------------------------------------
// flash_xfer_hs
// Handshake with the SPI engine for one transaction: emits a one-cycle trigger,
// waits for the engine's busy to rise and then fall, and optionally times the
// CS-high gap before the next transaction may be issued.
//
// Ports
//   clk_i       in   clock, rising edge
//   rst_ni      in   asynchronous active-low reset
//   start_i     in   issue request (one cycle); trigger follows next cycle
//   gap_en_i    in   sampled on busy fall: 1 = run the gap timer afterwards
//   spi_busy_i  in   SPI engine busy
//   trig_o      out  registered one-cycle start pulse to the engine
//   fall_o      out  combinational: engine busy fell this cycle
//   gap_done_o  out  combinational: last cycle of the gap
// -----------------------------------------------------------------------------
module flash_xfer_hs
    import flash_seq_pkg::*;
#(
    parameter int GAP_CYC = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic gap_en_i,
    input  logic spi_busy_i,
    output logic trig_o,
    output logic fall_o,
    output logic gap_done_o
);

    hs_phase_e   phase_q, phase_d;
    logic [15:0] cnt_q, cnt_d;
    logic        trig_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= HS_IDLE;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            trig_q  <= start_i;
        end
    end

    always_comb begin
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        fall_o     = 1'b0;
        gap_done_o = 1'b0;
        case (phase_q)
            HS_IDLE: begin
                if (start_i) phase_d = HS_RISE;
            end
            // The trigger cycle itself is spent here, so a busy that rises
            // in response to the trigger is caught on the following edge.
            HS_RISE: begin
                if (spi_busy_i) phase_d = HS_FALL;
            end
            HS_FALL: begin
                if (!spi_busy_i) begin
                    fall_o  = 1'b1;
                    cnt_d   = '0;
                    phase_d = gap_en_i ? HS_GAP : HS_IDLE;
                end
            end
            HS_GAP: begin
                // A zero gap still spends one cycle here.
                if (32'(cnt_q) + 32'd1 >= GAP_CYC) begin
                    gap_done_o = 1'b1;
                    phase_d    = HS_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: phase_d = HS_IDLE;
        endcase
    end

    assign trig_o = trig_q;

endmodule

// File: rtl/flash_op_seq.sv
// -----------------------------------------------------------------------------
// flash_op_seq
// Sequences SPI NOR flash operations (chip erase, sector erase, byte program,
// byte read) as a series of SPI transactions handed to an external engine:
//   erase/program: WREN -> command -> status poll repeated while WIP=1
//   read:          single read command, data byte captured on busy fall
//
// Build option
//   FLASH_SEQ_TIMEOUT_EN  when defined, POLL_MAX polls that all report WIP=1
//                         end the operation with op_err=1; otherwise polling
//                         is unbounded and op_err is tied low.
//
// Ports
//   sclk      in   system clock, rising edge
//   srst_n    in   asynchronous active-low reset
//   op_req    in   start pulse, sampled only in IDLE
//   op_code   in   0 chip erase, 1 sector erase, 2 byte program, 3 byte read
//   op_addr   in   flash byte address, latched on accept
//   op_wdata  in   program data, latched on accept
//   op_busy   out  high from the cycle after accept through the DONE cycle
//   op_done   out  one-cycle completion pulse
//   op_rdata  out  read byte, valid with op_done of a read, held until next read
//   op_err    out  poll timeout flag, valid with op_done
//   spi_trig  out  one-cycle start pulse to the SPI engine
//   spi_len   out  transaction length in bits
//   spi_tx    out  transmit data, right-justified, bit spi_len-1 sent first
//   spi_busy  in   SPI engine busy
//   spi_rx    in   received data, last received bit at bit 0
// -----------------------------------------------------------------------------
module flash_op_seq
    import flash_seq_pkg::*;
#(
    parameter int GAP_CYC  = 4,
    parameter int POLL_MAX = 65535
) (
    input  logic         sclk,
    input  logic         srst_n,
    input  logic         op_req,
    input  logic [1:0]   op_code,
    input  logic [23:0]  op_addr,
    input  logic [7:0]   op_wdata,
    output logic         op_busy,
    output logic         op_done,
    output logic [7:0]   op_rdata,
    output logic         op_err,
    output logic         spi_trig,
    input  logic         spi_busy,
    output logic [7:0]   spi_len,
    output logic [127:0] spi_tx,
    input  logic [127:0] spi_rx
);

    state_e       state_q, state_d;
    state_e       last_q, last_d;       // issue state of the transaction in flight
    logic [1:0]   code_q, code_d;
    logic [23:0]  addr_q, addr_d;
    logic [7:0]   wdata_q, wdata_d;
    logic [15:0]  poll_cnt_q, poll_cnt_d;
    logic [7:0]   rdata_q, rdata_d;
    logic [7:0]   len_q, len_d;
    logic [127:0] tx_q, tx_d;

    logic  accept;
    logic  hs_start, hs_gap_en, hs_fall, hs_gap_done;
    logic  poll_wip_end;                // a status poll just ended with WIP=1
    logic  timeout_hit;
    xfer_t cmd;

    assign accept       = (state_q == ST_IDLE) && op_req;
    assign poll_wip_end = (state_q == ST_XWAIT) && hs_fall && (last_q == ST_POLL) && spi_rx[0];
    assign cmd          = cmd_xfer(code_q, addr_q, wdata_q);

    flash_xfer_hs #(
        .GAP_CYC (GAP_CYC)
    ) u_hs (
        .clk_i      (sclk),
        .rst_ni     (srst_n),
        .start_i    (hs_start),
        .gap_en_i   (hs_gap_en),
        .spi_busy_i (spi_busy),
        .trig_o     (spi_trig),
        .fall_o     (hs_fall),
        .gap_done_o (hs_gap_done)
    );

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q    <= ST_IDLE;
            last_q     <= ST_IDLE;
            code_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            poll_cnt_q <= '0;
            rdata_q    <= '0;
            len_q      <= '0;
            tx_q       <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            code_q     <= code_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            poll_cnt_q <= poll_cnt_d;
            rdata_q    <= rdata_d;
            len_q      <= len_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        code_d     = code_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        poll_cnt_d = poll_cnt_q;
        rdata_d    = rdata_q;
        len_d      = len_q;
        tx_d       = tx_q;
        hs_start   = 1'b0;
        hs_gap_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    code_d     = op_code;
                    addr_d     = op_addr;
                    wdata_d    = op_wdata;
                    poll_cnt_d = '0;
                    state_d    = (op_code == OP_READ) ? ST_CMD : ST_WREN;
                end
            end
            // Issue states load len/tx; they stay untouched until the next
            // issue, which keeps them stable for the whole transaction.
            ST_WREN: begin
                len_d    = XFER_WREN.len;
                tx_d     = XFER_WREN.tx;
                hs_start = 1'b1;
                last_d   = ST_WREN;
                state_d  = ST_XWAIT;
            end
            ST_CMD: begin
                len_d    = cmd.len;
                tx_d     = cmd.tx;
                hs_start = 1'b1;
                last_d   = ST_CMD;
                state_d  = ST_XWAIT;
            end
            ST_POLL: begin
                len_d      = XFER_RDSR.len;
                tx_d       = XFER_RDSR.tx;
                poll_cnt_d = sat_inc16(poll_cnt_q);
                hs_start   = 1'b1;
                last_d     = ST_POLL;
                state_d    = ST_XWAIT;
            end
            ST_XWAIT: begin
                if (hs_fall) begin
                    case (last_q)
                        ST_CMD: begin
                            if (code_q == OP_READ) begin
                                rdata_d = spi_rx[7:0];
                                state_d = ST_DONE;
                            end else begin
                                hs_gap_en = 1'b1;
                                state_d   = ST_GAP;
                            end
                        end
                        ST_POLL: begin
                            if (!spi_rx[0] || timeout_hit) begin
                                state_d = ST_DONE;
                            end else begin
                                hs_gap_en = 1'b1;
                                state_d   = ST_GAP;
                            end
                        end
                        default: begin
                            hs_gap_en = 1'b1;
                            state_d   = ST_GAP;
                        end
                    endcase
                end
            end
            ST_GAP: begin
                if (hs_gap_done) state_d = (last_q == ST_WREN) ? ST_CMD : ST_POLL;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef FLASH_SEQ_TIMEOUT_EN
    logic err_q;

    // poll_cnt_q already includes the poll that just ended.
    assign timeout_hit = (32'(poll_cnt_q) >= POLL_MAX);

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (poll_wip_end && timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign op_err = err_q;
`else
    logic unused_poll;

    assign timeout_hit = 1'b0;
    assign op_err      = 1'b0;
    assign unused_poll = poll_wip_end ^ (POLL_MAX != 0);
`endif

    logic unused_rx;
    assign unused_rx = ^spi_rx[127:8];

    assign op_busy  = (state_q != ST_IDLE);
    assign op_done  = (state_q == ST_DONE);
    assign op_rdata = rdata_q;
    assign spi_len  = len_q;
    assign spi_tx   = tx_q;

endmodule

// File: tb/tb_flash_op_seq.sv
module tb_flash_op_seq;

    localparam int GAP = 4;
`ifdef FLASH_SEQ_TIMEOUT_EN
    localparam int PMAX  = 5;
    localparam bit TO_EN = 1'b1;
`else
    localparam int PMAX  = 65535;
    localparam bit TO_EN = 1'b0;
`endif

    logic         sclk, srst_n;
    logic         op_req;
    logic [1:0]   op_code;
    logic [23:0]  op_addr;
    logic [7:0]   op_wdata;
    logic         op_busy, op_done, op_err;
    logic [7:0]   op_rdata;
    logic         spi_trig, spi_busy;
    logic [7:0]   spi_len;
    logic [127:0] spi_tx, spi_rx;

    flash_op_seq #(
        .GAP_CYC  (GAP),
        .POLL_MAX (PMAX)
    ) dut (
        .sclk     (sclk),
        .srst_n   (srst_n),
        .op_req   (op_req),
        .op_code  (op_code),
        .op_addr  (op_addr),
        .op_wdata (op_wdata),
        .op_busy  (op_busy),
        .op_done  (op_done),
        .op_rdata (op_rdata),
        .op_err   (op_err),
        .spi_trig (spi_trig),
        .spi_busy (spi_busy),
        .spi_len  (spi_len),
        .spi_tx   (spi_tx),
        .spi_rx   (spi_rx)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    always @(posedge sclk) cyc <= cyc + 1;
    always @(negedge sclk) if (op_done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Flash contents as the emulated device sees them (driven by DUT traffic)
    // and as the reference expects them (driven by the requested operations).
    logic [7:0] fmem [int unsigned];
    logic [7:0] emem [int unsigned];

    function automatic logic [7:0] flash_byte(input int unsigned a);
        if (fmem.exists(a)) return fmem[a];
        return 8'hFF;
    endfunction

    function automatic logic [7:0] exp_byte(input int unsigned a);
        if (emem.exists(a)) return emem[a];
        return 8'hFF;
    endfunction

    task automatic flash_sector_erase(input int unsigned a);
        int unsigned ks[$];
        foreach (fmem[k]) if ((k >> 12) == (a >> 12)) ks.push_back(k);
        foreach (ks[i]) fmem.delete(ks[i]);
    endtask

    task automatic exp_sector_erase(input int unsigned a);
        int unsigned ks[$];
        foreach (emem[k]) if ((k >> 12) == (a >> 12)) ks.push_back(k);
        foreach (ks[i]) emem.delete(ks[i]);
    endtask

    // ---------------- SPI engine + flash device emulation ----------------
    int           wip_left = 0;
    bit           eng_active = 0;
    int           last_fall_cyc = 0;
    int           log_len[$];
    logic [127:0] log_tx[$];

    initial begin
        logic [7:0]   l;
        logic [127:0] t;
        logic [7:0]   opc;
        int           d;
        bit           stable;
        spi_busy = 1'b0;
        spi_rx   = '0;
        forever begin
            @(negedge sclk);
            if (srst_n && spi_trig) begin
                l = spi_len;
                t = spi_tx;
                eng_active = 1'b1;
                stable = 1'b1;
                if (log_len.size() > 0)
                    check_eq("cs_gap", 128'(cyc - last_fall_cyc >= GAP), 128'd1);
                log_len.push_back(int'(l));
                log_tx.push_back(t);
                d = $urandom_range(0, 2);
                repeat (d) begin
                    @(negedge sclk);
                    if (srst_n && (spi_len !== l || spi_tx !== t)) stable = 1'b0;
                end
                spi_busy = 1'b1;
                d = $urandom_range(1, 4);
                repeat (d) begin
                    @(negedge sclk);
                    if (srst_n && (spi_len !== l || spi_tx !== t)) stable = 1'b0;
                end
                opc = (l < 8'd8) ? 8'h00 : 8'(t >> (int'(l) - 8));
                spi_rx = {$urandom, $urandom, $urandom, $urandom};
                case (opc)
                    8'h05: begin
                        spi_rx[7:0] = {7'($urandom), 1'(wip_left > 0)};
                        if (wip_left > 0) wip_left--;
                    end
                    8'h03: spi_rx[7:0] = flash_byte(int'(t[31:8]));
                    8'h02: fmem[int'(t[31:8])] = t[7:0];
                    8'h20: flash_sector_erase(int'(t[23:0]));
                    8'hC7: fmem.delete();
                    default: ;
                endcase
                spi_busy = 1'b0;
                last_fall_cyc = cyc;
                eng_active = 1'b0;
                check_eq("xfer_stable", 128'(stable), 128'd1);
            end
        end
    end

    // ---------------- reference model + operation driver ----------------
    logic [7:0] last_rd = 8'h00;

    task automatic run_op(input logic [1:0] code, input logic [23:0] addr,
                          input logic [7:0] wd, input int wip, input bit inject);
        int           elen[$];
        logic [127:0] etx[$];
        int           npoll;
        bit           eerr;
        int           d0, inj_at, n;
        bit           got_done;
        eerr = 1'b0;
        if (code != 2'd3) begin
            elen.push_back(8);
            etx.push_back(128'h06);
        end
        case (code)
            2'd0: begin elen.push_back(8);  etx.push_back(128'hC7); end
            2'd1: begin elen.push_back(32); etx.push_back(128'({8'h20, addr})); end
            2'd2: begin elen.push_back(40); etx.push_back(128'({8'h02, addr, wd})); end
            default: begin elen.push_back(40); etx.push_back(128'({8'h03, addr, 8'h00})); end
        endcase
        if (code != 2'd3) begin
            if (TO_EN && wip >= PMAX) begin
                npoll = PMAX;
                eerr  = 1'b1;
            end else begin
                npoll = wip + 1;
            end
            repeat (npoll) begin
                elen.push_back(16);
                etx.push_back(128'h0500);
            end
        end else begin
            last_rd = exp_byte(int'(addr));
        end

        log_len.delete();
        log_tx.delete();
        wip_left = wip;
        d0 = done_cnt;
        @(negedge sclk);
        op_req = 1'b1; op_code = code; op_addr = addr; op_wdata = wd;
        @(negedge sclk);
        op_req = 1'b0; op_code = 2'($urandom); op_addr = 24'($urandom); op_wdata = 8'($urandom);
        check_eq("busy_after_accept", 128'(op_busy), 128'd1);
        inj_at = $urandom_range(1, 6);
        got_done = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (op_done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            if (inject && c == inj_at && op_busy) begin
                op_req = 1'b1;
                op_code = 2'($urandom);
            end
            @(negedge sclk);
            op_req = 1'b0;
        end
        op_req = 1'b0;
        check_eq("op_done_seen", 128'(got_done), 128'd1);
        check_eq("op_err", 128'(op_err), 128'(eerr));
        check_eq("op_rdata", 128'(op_rdata), 128'(last_rd));
        @(negedge sclk);
        check_eq("busy_after_done", 128'(op_busy), 128'd0);
        check_eq("done_one_cycle", 128'(op_done), 128'd0);
        @(negedge sclk);
        check_eq("done_count", 128'(done_cnt - d0), 128'd1);
        check_eq("xfer_count", 128'(log_len.size()), 128'(elen.size()));
        n = (log_len.size() < elen.size()) ? log_len.size() : elen.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("xfer%0d_len", i), 128'(log_len[i]), 128'(elen[i]));
            check_eq($sformatf("xfer%0d_tx", i), log_tx[i], etx[i]);
        end
        case (code)
            2'd0: emem.delete();
            2'd1: exp_sector_erase(int'(addr));
            2'd2: emem[int'(addr)] = wd;
            default: ;
        endcase
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_busy"},  128'(op_busy),  128'd0);
        check_eq({pfx, "_done"},  128'(op_done),  128'd0);
        check_eq({pfx, "_err"},   128'(op_err),   128'd0);
        check_eq({pfx, "_trig"},  128'(spi_trig), 128'd0);
        check_eq({pfx, "_len"},   128'(spi_len),  128'd0);
        check_eq({pfx, "_tx"},    spi_tx,         128'd0);
        check_eq({pfx, "_rdata"}, 128'(op_rdata), 128'd0);
    endtask

    task automatic mid_poll_reset();
        int  d0;
        bit  reached;
        reached = 1'b0;
        log_len.delete();
        log_tx.delete();
        wip_left = 20;
        @(negedge sclk);
        op_req = 1'b1; op_code = 2'd2; op_addr = 24'h000345; op_wdata = 8'h3C;
        @(negedge sclk);
        op_req = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (log_len.size() >= 3) begin
                reached = 1'b1;
                break;
            end
            @(negedge sclk);
        end
        check_eq("reset_reached_poll", 128'(reached), 128'd1);
        d0 = done_cnt;
        @(negedge sclk);
        srst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        for (int c = 0; c < 50 && eng_active; c++) @(negedge sclk);
        repeat (3) @(negedge sclk);
        srst_n = 1'b1;
        wip_left = 0;
        repeat (6) @(negedge sclk);
        check_eq("midrst_no_done", 128'(done_cnt - d0), 128'd0);
        check_eq("midrst_idle", 128'(op_busy), 128'd0);
        last_rd = 8'h00;
        emem[32'h345] = 8'h3C;
    endtask

    initial begin
        srst_n = 1'b0;
        op_req = 1'b0;
        op_code = '0;
        op_addr = '0;
        op_wdata = '0;
        repeat (3) @(negedge sclk);
        check_outputs_zero("reset");
        srst_n = 1'b1;
        repeat (2) @(negedge sclk);

        run_op(2'd0, 24'h000000, 8'h00, 3, 1'b0);
        run_op(2'd1, 24'h012345, 8'h00, 1, 1'b0);
        fmem[32'h10] = 8'hA5;
        emem[32'h10] = 8'hA5;
        run_op(2'd3, 24'h000010, 8'h00, 0, 1'b0);
        run_op(2'd2, 24'h000020, 8'h5A, 2, 1'b0);
        run_op(2'd3, 24'h000020, 8'h00, 0, 1'b0);
        run_op(2'd2, 24'h000040, 8'h77, TO_EN ? 1000 : 7, 1'b0);
        run_op(2'd1, 24'h000123, 8'h00, 2, 1'b1);
        run_op(2'd3, 24'h000010, 8'h00, 0, 1'b1);

        mid_poll_reset();
        run_op(2'd3, 24'h000345, 8'h00, 0, 1'b0);
        run_op(2'd2, 24'h000346, 8'h99, 1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  c;
            logic [23:0] a;
            c = 2'($urandom_range(0, 3));
            a = 24'(($urandom_range(0, 1) << 12) | $urandom_range(0, 7));
            run_op(c, a, 8'($urandom), $urandom_range(0, TO_EN ? 6 : 4), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flash_op_seq.md
FLASH_OP_SEQ -- requirements
Module: flash_op_seq

Interface
REQ-001 SHALL have parameter GAP_CYC, default 4, sclk cycles of idle between consecutive SPI transactions (CS high time).
REQ-002 SHALL have parameter POLL_MAX, default 65535, maximum status polls per operation before timeout.
REQ-003 SHALL have port sclk  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port srst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port op_req  in  1  start pulse; sampled only in IDLE.
REQ-006 SHALL have port op_code  in  2  operation: 0 chip erase, 1 sector erase, 2 byte program, 3 byte read.
REQ-007 SHALL have port op_addr  in  24  flash byte address; latched on accept.
REQ-008 SHALL have port op_wdata  in  8  program data; latched on accept.
REQ-009 SHALL have port op_busy  out  1  high from the cycle after accept until DONE.
REQ-010 SHALL have port op_done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port op_rdata  out  8  read result; valid with op_done for op_code 3; holds until next read.
REQ-012 SHALL have port op_err  out  1  timeout flag; valid with op_done.
REQ-013 SHALL have port spi_trig  out  1  one-cycle start pulse to the SPI engine.
REQ-014 SHALL have port spi_len  out  8  transaction length in bits.
REQ-015 SHALL have port spi_tx  out  128  transmit data, right-justified, MSB of bit spi_len-1 sent first.
REQ-016 SHALL have port spi_busy  in  1  SPI engine busy.
REQ-017 SHALL have port spi_rx  in  128  received data, last received bit at bit 0.

Function
REQ-018 SHALL use states IDLE, WREN, CMD, POLL, XWAIT, GAP, DONE.
REQ-019 SHALL, on op_req=1 in IDLE, latch op_code/op_addr/op_wdata and go to WREN (codes 0-2) or CMD (code 3).
REQ-020 SHALL ignore op_req in any state except IDLE.
REQ-021 WREN SHALL issue len 8, tx 0x06.
REQ-022 CMD SHALL issue: code 0 len 8 tx 0xC7; code 1 len 32 tx {0x20,addr}; code 2 len 40 tx {0x02,addr,wdata}; code 3 len 40 tx {0x03,addr,0x00}.
REQ-023 POLL SHALL issue len 16 tx {0x05,0x00}; status = spi_rx[7:0], WIP = bit 0.
REQ-024 Each issue SHALL pulse spi_trig one cycle with spi_len/spi_tx stable from that cycle until spi_busy falls.
REQ-025 XWAIT SHALL wait for spi_busy=1 then spi_busy=0; GAP SHALL then count GAP_CYC cycles before the next issue.
REQ-026 Sequence SHALL be WREN->CMD->POLL repeated while WIP=1 for codes 0-2; CMD only for code 3.
REQ-027 Code 3 SHALL capture op_rdata = spi_rx[7:0] when spi_busy falls.
REQ-028 DONE SHALL last one cycle (op_done=1, op_busy=0 next cycle) then return to IDLE; op_req in the DONE cycle is ignored.
REQ-029 Poll counter SHALL be 16-bit, cleared on accept, saturating; no wrap-around.

Reset
REQ-030 srst_n=0 SHALL immediately force IDLE and op_busy, op_done, op_err, spi_trig, spi_len, spi_tx, op_rdata, counters to 0.
REQ-031 Reset mid-operation SHALL abort without completing the sequence or pulsing op_done.

Configuration
REQ-032 With FLASH_SEQ_TIMEOUT_EN defined, reaching POLL_MAX polls with WIP=1 SHALL go to DONE with op_err=1.
REQ-033 Without FLASH_SEQ_TIMEOUT_EN, polling SHALL be unbounded and op_err SHALL be constant 0.

Structure
REQ-034 Package flash_seq_pkg SHALL hold flash opcode constants (06,C7,20,02,03,05), op_code encodings and state encoding.
REQ-035 Sub-module flash_xfer_hs SHALL implement the trig/busy-rise/busy-fall/GAP handshake (REQ-024/025) as one reusable unit.

Verification
REQ-036 Chip erase, status model WIP=1 for 3 polls -> tx sequence 0x06, 0xC7, 0x0500 x4; op_done once, op_err=0.
REQ-037 Sector erase addr 0x012345 -> second transaction len 32, tx 0x20012345.
REQ-038 Read addr 0x000010, model returns 0xA5 -> single transaction len 40, op_rdata=0xA5, no WREN/POLL.
REQ-039 Macro defined, POLL_MAX=5, WIP stuck 1 -> exactly 5 polls, op_done with op_err=1.
REQ-040 srst_n low during POLL of program -> outputs 0 next edge, no op_done; new op_req after release runs normally.
REQ-041 op_req pulsed while busy -> ignored; transaction count unchanged.
